match_report_scheduler: RTL
===========================

MATCH_REPORT_SCHEDULER -- requirements
Module: match_report_scheduler

Interface
REQ-001 The block SHALL have parameter MATCH_SCORE_WIDTH, default 32, signed score width; fixed at 32 for packet framing.
REQ-002 The block SHALL have parameter LAG_WIDTH, default 16, width of the per-filter lag counters.
REQ-003 The block SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 The block SHALL have port run_start, input, 1, one-cycle pulse marking the start of a filter run.
REQ-006 The block SHALL have port run_done, input, 1, one-cycle pulse marking the end of a filter run.
REQ-007 The block SHALL have port f0_axiiv, input, 1, filter-0 score valid.
REQ-008 The block SHALL have port f0_axiid, input, MATCH_SCORE_WIDTH, filter-0 signed score.
REQ-009 The block SHALL have ports f1_axiiv and f1_axiid, matching REQ-007/008, for filter 1.
REQ-010 The block SHALL have port uart_axiiv, output, 1, byte valid to the UART.
REQ-011 The block SHALL have port uart_axiid, output, 8, byte to the UART.
REQ-012 The block SHALL have port uart_axiready, input, 1, UART ready.
REQ-013 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 The block SHALL have port winner, output, 1, index of the filter with the larger peak.
REQ-015 The block SHALL have port winner_valid, output, 1, high while winner holds a finished run's result.

Function
REQ-016 The state machine SHALL have states IDLE, ACCUM and REPORT.
REQ-017 IDLE SHALL go to ACCUM on run_start: peaks to the most negative value (0x80000000), lag counters, peak lags and winner_valid cleared the next cycle.
REQ-018 In ACCUM, each fN_axiiv cycle SHALL increment lag counter N, saturating at all-ones.
REQ-019 In ACCUM, when fN_axiid is signed-greater than peak N, peak N and peak lag N SHALL both update, the lag taking the pre-increment count.
REQ-020 Ties SHALL keep the earlier peak (strict greater-than).
REQ-021 Scores valid in the same cycle as run_done SHALL be included in the peaks.
REQ-022 run_start in ACCUM without run_done SHALL restart accumulation as in REQ-017.
REQ-023 run_done SHALL take priority over run_start when both occur in the same cycle.
REQ-024 On run_done in ACCUM, the block SHALL go to REPORT and set winner = (peak1 > peak0) and winner_valid = 1 one cycle later, with ties giving winner 0.
REQ-025 run_done in IDLE or REPORT SHALL be ignored.
REQ-026 run_start and fN_axiiv in REPORT SHALL be ignored.
REQ-027 REPORT SHALL emit, in order:
- 0xA5
- peak0, 4 bytes, MSB first
- peak lag0, 2 bytes, MSB first
- peak1, 4 bytes, MSB first
- peak lag1, 2 bytes, MSB first
- winner byte 0x00 or 0x01
REQ-028 A byte SHALL transfer only on a cycle with uart_axiiv and uart_axiready both high.
REQ-029 uart_axiiv SHALL be held and uart_axiid SHALL be held stable until the transfer completes.
REQ-030 uart_axiiv SHALL assert no later than the cycle after the previous transfer.
REQ-031 After the last byte transfers, the block SHALL return to IDLE, with uart_axiiv low the next cycle.
REQ-032 winner and winner_valid SHALL hold until the next accepted run_start.

Reset
REQ-033 rst SHALL force IDLE and drive uart_axiiv=0, uart_axiid=0x00, busy=0, winner=0, winner_valid=0, with all peaks and counters cleared.
REQ-034 rst SHALL take effect mid-packet, abandoning the packet with no further bytes emitted.

Configuration
REQ-035 With REPORT_CHECKSUM_EN defined, the packet SHALL append a 15th byte equal to the XOR of bytes 2-14.
REQ-036 Without REPORT_CHECKSUM_EN defined, the packet SHALL be 14 bytes and SHALL contain no checksum logic.

Verification
REQ-037 The bench SHALL cover: run_start; f0 scores 5,-3,9,9 and f1 scores 2,7,1,0, one pair per cycle; run_done -> bytes A5 00000009 0002 00000007 0001 00, and checksum 0x0D if REPORT_CHECKSUM_EN.
REQ-038 The bench SHALL cover: all scores negative, f0=-10 and f1=-4 -> peak1 FFFFFFFC, winner=1, winner_valid=1 after run_done.
REQ-039 The bench SHALL cover: uart_axiready toggling 1 cycle high / 5 cycles low -> no byte dropped or duplicated, uart_axiid stable while stalled.
REQ-040 The bench SHALL cover: run_start and run_done in the same ACCUM cycle -> REPORT entered, peaks not cleared.
REQ-041 The bench SHALL cover: rst asserted after the 6th byte transfer -> uart_axiiv=0 next cycle, busy=0, winner_valid=0, no further bytes.
REQ-042 The bench SHALL cover: 70000 f0 valids with the peak on the last -> lag0 = 0xFFFF (saturated).

Source files
------------

// File: rtl/match_report_scheduler.sv
// Tracks per-filter peak scores and their lags over a run, then streams a report packet to a UART.
// Optional define REPORT_CHECKSUM_EN appends an XOR checksum byte to the packet.
module match_report_scheduler #(
  parameter int unsigned MATCH_SCORE_WIDTH = 32,
  parameter int unsigned LAG_WIDTH         = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                run_start,
  input  logic                                run_done,
  input  logic                                f0_axiiv,
  input  logic signed [MATCH_SCORE_WIDTH-1:0] f0_axiid,
  input  logic                                f1_axiiv,
  input  logic signed [MATCH_SCORE_WIDTH-1:0] f1_axiid,
  output logic                                uart_axiiv,
  output logic [7:0]                          uart_axiid,
  input  logic                                uart_axiready,
  output logic                                busy,
  output logic                                winner,
  output logic                                winner_valid
);

  localparam int unsigned BODY_LEN = 13;
`ifdef REPORT_CHECKSUM_EN
  localparam int unsigned PKT_LEN = BODY_LEN + 2;
`else
  localparam int unsigned PKT_LEN = BODY_LEN + 1;
`endif
  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
  localparam logic signed [MATCH_SCORE_WIDTH-1:0] SCORE_MIN =
    {1'b1, {(MATCH_SCORE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  state_t state, state_next;
  logic signed [MATCH_SCORE_WIDTH-1:0] peak0, peak0_next, peak1, peak1_next;
  logic signed [MATCH_SCORE_WIDTH-1:0] acc_peak0, acc_peak1;
  logic [LAG_WIDTH-1:0] lag0, lag0_next, lag1, lag1_next;
  logic [LAG_WIDTH-1:0] plag0, plag0_next, plag1, plag1_next;
  logic [LAG_WIDTH-1:0] acc_lag0, acc_lag1, acc_plag0, acc_plag1;
  logic [IDX_W-1:0] idx, idx_next;
  logic uart_valid_next, winner_next, winner_valid_next;
  logic [7:0] uart_data_next;
  logic [8*BODY_LEN-1:0] body;
  logic [7:0] pkt [PKT_LEN];

  // Scores of the current cycle folded into the running peaks (ties keep the earlier peak)
  always_comb begin
    acc_peak0 = peak0;
    acc_plag0 = plag0;
    acc_lag0  = lag0;
    acc_peak1 = peak1;
    acc_plag1 = plag1;
    acc_lag1  = lag1;
    if (f0_axiiv) begin
      if (lag0 != '1) acc_lag0 = lag0 + LAG_WIDTH'(1);
      if (f0_axiid > peak0) begin
        acc_peak0 = f0_axiid;
        acc_plag0 = lag0;
      end
    end
    if (f1_axiiv) begin
      if (lag1 != '1) acc_lag1 = lag1 + LAG_WIDTH'(1);
      if (f1_axiid > peak1) begin
        acc_peak1 = f1_axiid;
        acc_plag1 = lag1;
      end
    end
  end

  // Packet image: header, big-endian fields, winner byte, optional checksum
  always_comb begin
    body = {32'(peak0), 16'(plag0), 32'(peak1), 16'(plag1), 8'(winner)};
    pkt[0] = 8'hA5;
    for (int i = 0; i < int'(BODY_LEN); i++) begin
      pkt[i+1] = body[8*(int'(BODY_LEN)-1-i) +: 8];
    end
`ifdef REPORT_CHECKSUM_EN
    pkt[PKT_LEN-1] = 8'h00;
    for (int i = 0; i < int'(BODY_LEN); i++) begin
      pkt[PKT_LEN-1] = pkt[PKT_LEN-1] ^ body[8*i +: 8];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      peak0        <= '0;
      peak1        <= '0;
      lag0         <= '0;
      lag1         <= '0;
      plag0        <= '0;
      plag1        <= '0;
      idx          <= '0;
      uart_axiiv   <= 1'b0;
      uart_axiid   <= 8'h00;
      busy         <= 1'b0;
      winner       <= 1'b0;
      winner_valid <= 1'b0;
    end else begin
      state        <= state_next;
      peak0        <= peak0_next;
      peak1        <= peak1_next;
      lag0         <= lag0_next;
      lag1         <= lag1_next;
      plag0        <= plag0_next;
      plag1        <= plag1_next;
      idx          <= idx_next;
      uart_axiiv   <= uart_valid_next;
      uart_axiid   <= uart_data_next;
      busy         <= (state_next != IDLE);
      winner       <= winner_next;
      winner_valid <= winner_valid_next;
    end
  end

  always_comb begin
    state_next        = state;
    peak0_next        = peak0;
    peak1_next        = peak1;
    lag0_next         = lag0;
    lag1_next         = lag1;
    plag0_next        = plag0;
    plag1_next        = plag1;
    idx_next          = idx;
    uart_valid_next   = uart_axiiv;
    uart_data_next    = uart_axiid;
    winner_next       = winner;
    winner_valid_next = winner_valid;
    unique case (state)
      IDLE: begin
        if (run_start) begin
          state_next        = ACCUM;
          peak0_next        = SCORE_MIN;
          peak1_next        = SCORE_MIN;
          lag0_next         = '0;
          lag1_next         = '0;
          plag0_next        = '0;
          plag1_next        = '0;
          winner_valid_next = 1'b0;
        end
      end
      ACCUM: begin
        if (run_done) begin
          state_next        = REPORT;
          peak0_next        = acc_peak0;
          peak1_next        = acc_peak1;
          lag0_next         = acc_lag0;
          lag1_next         = acc_lag1;
          plag0_next        = acc_plag0;
          plag1_next        = acc_plag1;
          winner_next       = (acc_peak1 > acc_peak0);
          winner_valid_next = 1'b1;
          idx_next          = '0;
          uart_valid_next   = 1'b1;
          uart_data_next    = 8'hA5;
        end else if (run_start) begin
          peak0_next = SCORE_MIN;
          peak1_next = SCORE_MIN;
          lag0_next  = '0;
          lag1_next  = '0;
          plag0_next = '0;
          plag1_next = '0;
        end else begin
          peak0_next = acc_peak0;
          peak1_next = acc_peak1;
          lag0_next  = acc_lag0;
          lag1_next  = acc_lag1;
          plag0_next = acc_plag0;
          plag1_next = acc_plag1;
        end
      end
      REPORT: begin
        if (uart_axiiv && uart_axiready) begin
          if (idx == LAST_IDX) begin
            state_next      = IDLE;
            uart_valid_next = 1'b0;
            uart_data_next  = 8'h00;
          end else begin
            idx_next       = idx + IDX_W'(1);
            uart_data_next = pkt[idx + IDX_W'(1)];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
